// File: rtl/alu_apb_pkg.sv
// alu_apb_pkg - shared types and default widths for the ALU APB initiator.
//
// Contents:
//   ADDR_W_DEF       default MSB index of the APB address.
//                    Taken from the `ADDR_W macro, or 4 if the macro is absent.
//   BUS_SIZE_DEF     default APB data width.
//                    Taken from the `APB_BUS_SIZE macro, or 32 if the macro is absent.
//   apb_mst_state_e  initiator state encoding: IDLE, SETUP, ACCESS, RESP.
//   apb_cmd_t        one command: write flag, address, write data.
//   apb_rsp_t        one response: read data, error flag.

`ifndef ADDR_W
`define ADDR_W 4
`endif

`ifndef APB_BUS_SIZE
`define APB_BUS_SIZE 32
`endif

package alu_apb_pkg;

    localparam int ADDR_W_DEF   = `ADDR_W;
    localparam int BUS_SIZE_DEF = `APB_BUS_SIZE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    typedef struct packed {
        logic                    write;
        logic [ADDR_W_DEF:0]     addr;
        logic [BUS_SIZE_DEF-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic [BUS_SIZE_DEF-1:0] rdata;
        logic                    err;
    } apb_rsp_t;

endpackage

// File: rtl/alu_apb_master_timeout_cnt.sv
// apb_mst_timeout_cnt - ACCESS-phase wait counter for the ALU APB initiator.
// This module is instantiated only when APB_MST_TIMEOUT_EN is defined.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active-high
//   clear    in   restart the count from zero; pulsed when a command is accepted
//   count_en in   count one ACCESS cycle
//   expired  out  high during the TIMEOUT_CYCLES-th counted cycle

module apb_mst_timeout_cnt
    import alu_apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // The count holds the number of ACCESS cycles that have already completed.
    // It therefore reads TIMEOUT_CYCLES-1 during the last cycle the initiator
    // is allowed to wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_apb_master.sv
// alu_apb_master - single-outstanding APB initiator for the ALU subsystem.
//
// The module accepts one command on a valid/ready port. It then runs the APB
// SETUP and ACCESS phases against the ALU responder. Finally it returns the
// read data and error flag on a valid/ready response port.
//
// Optional feature:
//   Define APB_MST_TIMEOUT_EN to abort an ACCESS phase that waits longer than
//   TIMEOUT_CYCLES cycles. An aborted transfer is reported with rsp_err = 1.
//
// Ports:
//   clk, rst                        clock, and asynchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write/cmd_addr/cmd_wdata    command payload
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata/rsp_err               response payload (rdata is 0 for writes)
//   psel/penable/pwrite             APB control
//   paddr/pwdata                    APB request
//   prdata/ready/slv_err            APB completion (pready, pslverr)

module alu_apb_master
    import alu_apb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int APB_BUS_SIZE   = BUS_SIZE_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_W:0]         cmd_addr,
    input  logic [APB_BUS_SIZE-1:0] cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [APB_BUS_SIZE-1:0] rsp_rdata,
    output logic                    rsp_err,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_W:0]         paddr,
    output logic [APB_BUS_SIZE-1:0] pwdata,
    input  logic [APB_BUS_SIZE-1:0] prdata,
    input  logic                    ready,
    input  logic                    slv_err
);

    apb_mst_state_e state;
    apb_mst_state_e state_next;

    logic accept;
    logic done;
    logic timeout;

    assign accept = (state == IDLE) && cmd_valid;
    assign done   = (state == ACCESS) && ready;

`ifdef APB_MST_TIMEOUT_EN
    logic expired;

    apb_mst_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .count_en(state == ACCESS),
        .expired (expired)
    );

    assign timeout = expired && (state == ACCESS);
`else
    // The feature is disabled, so the abort path is always low.
    // TIMEOUT_CYCLES is never negative, which makes this comparison constant 0.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    // State register. Reset is asynchronous, so psel/penable, which are
    // decoded from the state, drop as soon as rst rises. A transfer that is
    // in flight at that moment is simply abandoned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the handshake/APB control decode.
    // SETUP always lasts exactly one cycle. ACCESS lasts until ready, or until
    // the optional timeout fires. A completed ready response has priority over
    // a timeout that expires in the same cycle.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                psel       = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (ready || timeout) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request and response registers.
    // The command is latched at accept time, so paddr/pwrite/pwdata stay
    // stable for the whole transfer even if the requester changes its inputs.
    // The response is captured only on the completing edge and then held
    // through RESP. slv_err therefore has no effect while ready is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
            end
            if (done) begin
                rsp_rdata <= pwrite ? '0 : prdata;
                rsp_err   <= slv_err;
            end else if (timeout) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_apb_master.md
Name: alu_apb_master

Overview:
- APB initiator that drives the ALU's APB responder port on psel/penable/pwrite/paddr/pwdata and samples prdata/ready/slv_err.
- Accepts one command at a time from a simple valid/ready command port, runs the APB SETUP and ACCESS phases, and returns the read data and error status on a valid/ready response port.
- Used as the RTL bus driver in the ALU subsystem and as the reusable stimulus engine in the ALU test bench.

Parameters:
- ADDR_W, 4, MSB index of paddr; paddr is ADDR_W+1 bits wide.
- APB_BUS_SIZE, 32, width of pwdata and prdata.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; used only when APB_MST_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W+1  target address.
- cmd_wdata  in  APB_BUS_SIZE  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  APB_BUS_SIZE  read data; 0 for writes.
- rsp_err  out  1  slv_err captured, or timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W+1  APB address.
- pwdata  out  APB_BUS_SIZE  APB write data.
- prdata  in  APB_BUS_SIZE  APB read data.
- ready  in  1  APB pready from the responder.
- slv_err  in  1  APB pslverr from the responder.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - psel, penable, pwrite, rsp_valid and rsp_err are 0.
  - paddr, pwdata and rsp_rdata are 0.
  - cmd_ready is 1 once reset is released.
  - State goes to IDLE.
- State machine IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, register cmd_write, cmd_addr and cmd_wdata into pwrite, paddr and pwdata, then go to SETUP.
- SETUP (one cycle exactly): psel = 1, penable = 0, go to ACCESS.
- ACCESS:
  - psel = 1 and penable = 1 for as long as ready is low.
  - paddr, pwrite and pwdata stay stable for the whole transfer.
  - Sample ready on each clock edge.
  - When ready = 1:
    - Capture prdata into rsp_rdata (reads only; writes load 0).
    - Capture slv_err into rsp_err.
    - Drop psel and penable in the next cycle and go to RESP.
- RESP:
  - rsp_valid = 1 and cmd_ready = 0.
  - Hold rsp_rdata and rsp_err stable until rsp_ready = 1.
  - Then clear rsp_valid and return to IDLE.
  - If rsp_ready is already 1 on RESP entry, rsp_valid is high for exactly one cycle.
- Latency:
  - Command accepted at edge N gives SETUP in cycle N+1 and ACCESS from cycle N+2.
  - With zero wait states, rsp_valid is asserted in cycle N+3.
  - Minimum spacing between command accepts is 4 cycles.
- cmd_ready is 0 in SETUP, ACCESS and RESP. Commands offered then are not consumed, and the requester holds them.
- Only one transfer is in flight at a time; there is no pipelining.
- Boundaries:
  - slv_err is ignored while ready = 0.
  - prdata is registered unchanged; no width conversion.
  - cmd_addr is passed through unchanged, all ADDR_W+1 bits.
- Reset mid-transfer: psel and penable drop asynchronously, the transfer is abandoned, and no response is produced.

Optional Feature:
- APB_MST_TIMEOUT_EN defined:
  - A wait counter runs in ACCESS.
  - If ready is still 0 after TIMEOUT_CYCLES ACCESS cycles, the transfer aborts: psel and penable drop, rsp_err = 1, rsp_rdata = 0, and the state goes to RESP.
  - The counter clears on entering SETUP.
- Not defined: no counter; ACCESS waits indefinitely for ready.

Decomposition:
- Shared package alu_apb_pkg holds:
  - enum apb_mst_state_e {IDLE, SETUP, ACCESS, RESP};
  - struct apb_cmd_t {write, addr, wdata};
  - struct apb_rsp_t {rdata, err}.
- ADDR_W and APB_BUS_SIZE defaults come from the existing ADDR_W and APB_BUS_SIZE macros.
- One sub-module, apb_mst_timeout_cnt, contains the wait counter and is instantiated only under APB_MST_TIMEOUT_EN.

Test Plan:
- Write, zero-wait: cmd write addr 0x3, wdata 0x0000_00A5, ready tied to 1.
  - SETUP then one ACCESS cycle with paddr = 0x3, pwrite = 1, pwdata = 0xA5.
  - rsp_valid 3 cycles after accept, rsp_err = 0, rsp_rdata = 0.
- Read with 2 wait states: cmd read addr 0x5; ready high on the 3rd ACCESS cycle with prdata = 0xDEAD_BEEF.
  - penable high for exactly 3 cycles, paddr stable throughout.
  - rsp_rdata = 0xDEADBEEF.
- Error: slv_err = 1 together with ready.
  - rsp_err = 1.
  - A stray slv_err pulse while ready = 0 must not set rsp_err.
- Back-pressure: rsp_ready held 0 for 5 cycles.
  - rsp_valid and rsp_data held stable, cmd_ready = 0, a second cmd_valid is not accepted.
  - Accepted in the cycle after rsp_ready rises.
- Reset in ACCESS: assert rst mid-transfer.
  - psel = penable = 0 in the same cycle.
  - No rsp_valid afterwards; cmd_ready = 1 after release.
- Timeout (APB_MST_TIMEOUT_EN, TIMEOUT_CYCLES = 16): ready held 0.
  - Abort after 16 ACCESS cycles with rsp_err = 1 and rsp_rdata = 0.
